// File: rtl/gnn_pkg.sv
// Shared constants and types for the GNN result readout path.
package gnn_pkg;
    localparam int N_NODES = 4;
    localparam int N_OUT   = 2;
    localparam int N_RES   = N_NODES * N_OUT;
    localparam int DW      = 21;
    localparam int IW      = 3;

    typedef logic signed [DW-1:0] res_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;
endpackage

// File: rtl/gnn_frame_hold.sv
// Snapshot register bank for one result frame, read back one word at a time by index.
module gnn_frame_hold
    import gnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap,
    input  logic [N_RES*DW-1:0]   res_flat,
    input  logic [IW-1:0]         k,
    output res_t                  data
);

    res_t hold [N_RES];

    // Capture every word of the frame together; reset discards the snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RES; i++) hold[i] <= '0;
        end else if (cap) begin
            for (int i = 0; i < N_RES; i++) hold[i] <= res_t'(res_flat[i*DW +: DW]);
        end
    end

    assign data = hold[k];

endmodule

// File: rtl/gnn_result_serializer.sv
// Snapshots the GNN result frame once all ready flags are high and streams it
// word by word over valid/ready. Frames that arrive mid-stream are dropped and
// flagged as a sticky overrun.
module gnn_result_serializer
    import gnn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_RES*DW-1:0]         res_flat,
    input  logic [N_RES-1:0]            res_rdy_flat,
    output logic                        m_valid,
    input  logic                        m_ready,
    output res_t                        m_data,
    output logic [IW-1:0]               m_idx,
    output logic                        m_last,
    output logic                        busy,
    output logic [7:0]                  frame_cnt,
    output logic                        overrun
);

    ser_state_e    state, state_nxt;
    logic [IW-1:0] k, k_nxt;
    logic          armed, armed_nxt;
    logic [7:0]    cnt_nxt;
    logic          ovr_nxt;
    logic          cap;
    logic          all_rdy;
    logic          accept;
    logic          last_beat;

    assign all_rdy   = &res_rdy_flat;
    assign last_beat = (k == IW'(N_RES - 1));
    assign accept    = (state == SEND) && m_ready;

    gnn_frame_hold u_hold (
        .clk      (clk),
        .rst      (rst),
        .cap      (cap),
        .res_flat (res_flat),
        .k        (k),
        .data     (m_data)
    );

    // State, beat index, arming, frame counter and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            armed     <= 1'b1;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            armed     <= armed_nxt;
            frame_cnt <= cnt_nxt;
            overrun   <= ovr_nxt;
        end
    end

    // Next-state, capture/overrun decisions and stream outputs.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        armed_nxt = armed;
        cnt_nxt   = frame_cnt;
        ovr_nxt   = overrun;
        cap       = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b0;
        m_last    = 1'b0;
        m_idx     = k;

        unique case (state)
            IDLE: begin
                if (all_rdy && armed) begin
                    cap       = 1'b1;
                    armed_nxt = 1'b0;
                    k_nxt     = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_last  = last_beat;
                if (accept) begin
                    if (last_beat) begin
                        state_nxt = IDLE;
                        k_nxt     = '0;
                        cnt_nxt   = frame_cnt + 8'd1;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end
                // A frame ready on the final accepted beat is not an overrun:
                // it stays armed and gets captured from IDLE next cycle.
                if (all_rdy && armed && !(accept && last_beat)) begin
                    ovr_nxt   = 1'b1;
                    armed_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Any cycle with a flag low re-arms for the next frame.
        if (!all_rdy) armed_nxt = 1'b1;
    end

endmodule

// File: tb/tb_gnn_result_serializer.sv
// Scoreboard bench: a queue-level model decides which frames are captured,
// pushes their words, and a monitor compares every presented beat.
module tb_gnn_result_serializer;
    import gnn_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_RES*DW-1:0]   res_flat = '0;
    logic [N_RES-1:0]      res_rdy_flat = '0;
    logic                  m_ready = 1'b0;
    logic                  m_valid, m_last, busy, overrun;
    res_t                  m_data;
    logic [IW-1:0]         m_idx;
    logic [7:0]            frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   idx;
        res_t data;
        bit   last;
    } beat_t;

    beat_t exp_q[$];
    int    beats_left = 0;
    bit    mdl_armed  = 1;
    int    mdl_cnt    = 0;
    bit    mdl_ovr    = 0;

    gnn_result_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .res_flat     (res_flat),
        .res_rdy_flat (res_rdy_flat),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_idx        (m_idx),
        .m_last       (m_last),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int v);
        res_t w;
        w = res_t'(v);
        for (int i = 0; i < N_RES; i++) res_flat[i*DW +: DW] = w;
    endtask

    // Reference model: a frame is a batch of 8 words; capture only when idle
    // and armed, words leave one per accepted beat.
    always @(posedge clk) begin
        bit all_r, last_acc;
        beat_t b;
        if (rst) begin
            beats_left = 0;
            mdl_armed  = 1;
            mdl_cnt    = 0;
            mdl_ovr    = 0;
            exp_q.delete();
        end else begin
            all_r    = &res_rdy_flat;
            last_acc = (beats_left == 1) && m_ready;
            if (beats_left > 0) begin
                if (all_r && mdl_armed && !last_acc) begin
                    mdl_ovr   = 1;
                    mdl_armed = 0;
                end
                if (m_ready) begin
                    beats_left--;
                    if (beats_left == 0) mdl_cnt = (mdl_cnt + 1) % 256;
                end
            end else if (all_r && mdl_armed) begin
                for (int i = 0; i < N_RES; i++) begin
                    b.idx  = i;
                    b.data = res_t'(res_flat[i*DW +: DW]);
                    b.last = (i == N_RES - 1);
                    exp_q.push_back(b);
                end
                beats_left = N_RES;
                mdl_armed  = 0;
            end
            if (!all_r) mdl_armed = 1;
        end
    end

    // Monitor: status every cycle, head-of-queue on every presented beat.
    always @(negedge clk) begin
        check("m_valid", m_valid, beats_left > 0);
        check("busy", busy, beats_left > 0);
        check("frame_cnt", frame_cnt, mdl_cnt);
        check("overrun", overrun, mdl_ovr);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                check("m_idx", m_idx, exp_q[0].idx);
                check("m_data", m_data, exp_q[0].data);
                check("m_last", m_last, exp_q[0].last);
                if (m_ready && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int nom [N_RES] = '{-6358, -4188, -6309, -4455, -6287, -4587, -6309, -4455};
        logic [31:0] r;

        step(2);
        rst = 1'b0;
        step(1);
        check("rst_m_data", m_data, 0);
        check("rst_m_idx", m_idx, 0);
        check("rst_m_last", m_last, 0);

        // Nominal frame, then flags held high for 50+ clocks.
        for (int i = 0; i < N_RES; i++) res_flat[i*DW +: DW] = res_t'(nom[i]);
        m_ready = 1'b1;
        res_rdy_flat = '1;
        step(60);
        check("nominal_cnt", frame_cnt, 1);

        // One-clock flag drop re-arms; second frame of -589824.
        res_rdy_flat = '0;
        step(1);
        set_all(-589824);
        res_rdy_flat = '1;
        step(15);
        check("held_cnt", frame_cnt, 2);

        // Backpressure with m_ready pattern 1,0,0.
        res_rdy_flat = '0;
        for (int i = 0; i < N_RES; i++) res_flat[i*DW +: DW] = res_t'(nom[i]);
        step(1);
        res_rdy_flat = '1;
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 3 == 0);
            step(1);
        end
        m_ready = 1'b1;
        step(5);
        check("bp_cnt", frame_cnt, 3);

        // Overrun: stall mid-frame, present a second frame of 486000.
        m_ready = 1'b0;
        res_rdy_flat = '0;
        set_all(12345);
        step(1);
        res_rdy_flat = '1;
        step(3);
        res_rdy_flat = '0;
        step(1);
        set_all(486000);
        res_rdy_flat = '1;
        step(3);
        check("overrun_set", overrun, 1);
        m_ready = 1'b1;
        step(12);
        check("ovr_cnt", frame_cnt, 4);

        // Partial ready after reset: no capture.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        res_rdy_flat = 8'h7F;
        step(10);
        check("partial_valid", m_valid, 0);

        // Reset mid-frame, then a fresh frame from idx 0.
        res_rdy_flat = '1;
        for (int i = 0; i < N_RES; i++) res_flat[i*DW +: DW] = res_t'(nom[i]);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_valid", m_valid, 0);
        check("midrst_cnt", frame_cnt, 0);
        res_rdy_flat = '0;
        step(1);
        res_rdy_flat = '1;
        step(12);
        check("fresh_cnt", frame_cnt, 1);

        // Randomized flags, words and backpressure.
        for (int c = 0; c < 600; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom;
                    res_rdy_flat = r[N_RES-1:0];
                end else begin
                    for (int i = 0; i < N_RES; i++) begin
                        r = $urandom;
                        res_flat[i*DW +: DW] = r[DW-1:0];
                    end
                    res_rdy_flat = '1;
                end
            end
            step(1);
        end

        // Drain and confirm nothing was left unsent.
        res_rdy_flat = '0;
        m_ready = 1'b1;
        step(20);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnn_result_serializer.md
Name: gnn_result_serializer

Overview:
- Sits downstream of the 4-node GNN top and drains its output side: the 8 per-node results and their ready flags.
- Snapshots all results once every ready flag is high, then streams them one per beat over a valid/ready stream toward the host readout path.
- Detects new result frames that arrive before the current frame has drained, and reports them as overruns.

Parameters:
- N_NODES, 4, number of graph nodes.
- N_OUT, 2, outputs per node.
- DW, 21, result word width (two's complement).
- IW, 3, index width; equals clog2(N_NODES*N_OUT).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- res_flat  input  N_NODES*N_OUT*DW  result word k = node*N_OUT+out, placed at bits [k*DW +: DW]; k=0 is out0_node0, k=7 is out1_node3.
- res_rdy_flat  input  N_NODES*N_OUT  per-result ready flags; bit k maps to out1{out}_ready_node{node}.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DW  captured result word.
- m_idx  output  IW  index k of m_data.
- m_last  output  1  high on the beat where k = N_NODES*N_OUT-1.
- busy  output  1  high while a frame is held or being sent.
- frame_cnt  output  8  frames fully drained; wraps 255->0.
- overrun  output  1  sticky; set when a new frame is dropped.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, frame_cnt=0, overrun=0, armed=1. Reset asserted mid-frame discards the snapshot and drops m_valid on the next edge.
- all_rdy = &res_rdy_flat.
- IDLE:
  - if all_rdy && armed: capture all 8 words into a holding register; set armed=0; go to SEND with k=0.
  - m_valid rises on the cycle after capture, giving a capture latency of 1 clk.
- SEND:
  - m_valid=1, m_data=hold[k], m_idx=k, m_last=(k==7), busy=1.
  - On m_valid && m_ready: if k<7, then k++; else go to IDLE, frame_cnt++, m_valid=0.
  - m_data, m_idx and m_last stay stable while m_valid && !m_ready (AXI-style; no retraction).
  - Full throughput: 8 beats in 8 clks when m_ready is held high.
- Re-arm: armed returns to 1 on any cycle where all_rdy=0, in any state. A frame is therefore captured only once per in_ready cycle, even if the flags stay high for many clocks.
- Overrun:
  - Trigger: while in SEND, all_rdy rises again after a re-arm.
  - Effect: that frame is not captured, overrun is set, and armed is cleared.
  - The current frame keeps streaming unaltered.
  - overrun clears only on rst.
- Simultaneous events:
  - Last-beat accept and all_rdy && armed in the same cycle: go to IDLE; capture happens on the next cycle if the condition still holds. No overrun in this case.
  - Re-arm and capture in the same cycle cannot collide, because all_rdy is either 0 or 1.
- Arithmetic: data passes through bit-exact with no sign extension or saturation. frame_cnt wraps modulo 256.

Decomposition:
- Shared package gnn_pkg:
  - constants N_NODES, N_OUT, DW, IW;
  - typedef res_t = logic signed [DW-1:0];
  - enum ser_state_e {IDLE, SEND}.
- One sub-module, gnn_frame_hold: the 8xDW capture register bank with a capture enable and a k-indexed read mux. The FSM, re-arm, overrun and counter logic stay in the top.

Test Plan:
- Nominal frame: after rst, present results {-6358,-4188,-6309,-4455,-6287,-4587,-6309,-4455} with all flags set and m_ready=1 -> 8 beats, m_idx 0..7, m_data in that order, m_last only on idx 7, frame_cnt=1.
- Backpressure: nominal frame with m_ready toggling 1,0,0,1,... -> each word held stable while stalled, no loss or duplication, 8 accepts total.
- Held flags: flags stay high for 50 clks after a frame drains -> no second capture, frame_cnt stays 1. Drop flags 1 clk and raise them with all words = -589824 -> second frame streams 8x -589824, frame_cnt=2.
- Overrun: m_ready=0 mid-frame; flags drop, then rise with all words = 486000 -> overrun=1, first frame completes intact, 486000 never appears on m_data.
- Partial ready: only 7 of 8 flags high -> no capture, m_valid stays 0.
- Reset mid-frame: assert rst at beat 3 -> next clk m_valid=0, frame_cnt=0, overrun=0. A fresh frame then streams starting from idx 0.
